fg_prog_sequencer: RTL and testbench

FG_PROG_SEQUENCER -- requirements
Module: fg_prog_sequencer

---
 rtl/fg_prog_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fg_prog_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fg_prog_sequencer.sv
// Floating-gate program sequencer: settle, then N injection pulses separated by gaps.
// Latency: command accepted on edge 0, SETUP visible from cycle 1, first pulse at cycle SETTLE_CYC+1.
// Backpressure: cmd_ready is high only in IDLE; commands offered while busy wait (no queueing).
//
// Ports:
//   clk, reset          - single clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; cmd_row/col/npulse/width captured on accept
//   abort               - ends the running command (SETUP/PULSE/GAP only)
//   row_addr, col_addr  - registered decoder address, held after completion
//   dec_en, drain_sel_en, vinj_pulse - registered analog tile controls
//   busy, done, aborted, pulse_cnt   - status
module fg_prog_sequencer #(
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_row,
  input  logic [3:0]  cmd_col,
  input  logic [7:0]  cmd_npulse,
  input  logic [15:0] cmd_width,
  input  logic        abort,
  output logic [2:0]  row_addr,
  output logic [3:0]  col_addr,
  output logic        dec_en,
  output logic        drain_sel_en,
  output logic        vinj_pulse,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [7:0]  pulse_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_PULSE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYC - 1);

  logic [2:0]  state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [7:0]  npulse_q, npulse_nxt;
  logic [15:0] width_q, width_nxt;
  logic [7:0]  pcnt_nxt;
  logic [2:0]  row_nxt;
  logic [3:0]  col_nxt;
  logic        abort_flag, abort_flag_nxt;
  logic [15:0] pulse_load;
  logic        more_pulses;
  logic        active_nxt;

  // A zero width still produces a single-cycle pulse.
  assign pulse_load  = (width_q == 16'd0) ? 16'd0 : width_q - 16'd1;
  // Evaluated on the last pulse cycle: is another pulse still owed after this one?
  assign more_pulses = ({1'b0, pulse_cnt} + 9'd1) < {1'b0, npulse_q};

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    npulse_nxt     = npulse_q;
    width_nxt      = width_q;
    pcnt_nxt       = pulse_cnt;
    row_nxt        = row_addr;
    col_nxt        = col_addr;
    abort_flag_nxt = abort_flag;
    case (state)
      S_IDLE: begin
        // abort is ignored here, so a simultaneous command is still taken
        if (cmd_valid) begin
          state_nxt      = S_SETUP;
          timer_nxt      = SETTLE_LOAD;
          npulse_nxt     = cmd_npulse;
          width_nxt      = cmd_width;
          row_nxt        = cmd_row;
          col_nxt        = cmd_col;
          pcnt_nxt       = 8'd0;
          abort_flag_nxt = 1'b0;
        end
      end
      S_SETUP: begin
        if (abort) begin
          state_nxt      = S_DONE;
          abort_flag_nxt = 1'b1;
        end else if (timer == 16'd0) begin
          if (npulse_q == 8'd0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_PULSE;
            timer_nxt = pulse_load;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      S_PULSE: begin
        // A pulse that has reached its final cycle counts even if abort arrives with it.
        if (timer == 16'd0) begin
          pcnt_nxt = pulse_cnt + 8'd1;
        end
        if (abort) begin
          state_nxt      = S_DONE;
          abort_flag_nxt = 1'b1;
        end else if (timer == 16'd0) begin
          if (more_pulses) begin
            state_nxt = S_GAP;
            timer_nxt = GAP_LOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_nxt      = S_DONE;
          abort_flag_nxt = 1'b1;
        end else if (timer == 16'd0) begin
          state_nxt = S_PULSE;
          timer_nxt = pulse_load;
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign active_nxt = (state_nxt == S_SETUP) || (state_nxt == S_PULSE) || (state_nxt == S_GAP);

  // Outputs are decoded from the next state and registered, so they change
  // cleanly on the edge together with the state and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      timer        <= 16'd0;
      npulse_q     <= 8'd0;
      width_q      <= 16'd0;
      pulse_cnt    <= 8'd0;
      row_addr     <= 3'd0;
      col_addr     <= 4'd0;
      abort_flag   <= 1'b0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      dec_en       <= 1'b0;
      drain_sel_en <= 1'b0;
      vinj_pulse   <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      npulse_q     <= npulse_nxt;
      width_q      <= width_nxt;
      pulse_cnt    <= pcnt_nxt;
      row_addr     <= row_nxt;
      col_addr     <= col_nxt;
      abort_flag   <= abort_flag_nxt;
      cmd_ready    <= (state_nxt == S_IDLE);
      busy         <= (state_nxt != S_IDLE);
      dec_en       <= active_nxt;
      drain_sel_en <= active_nxt;
      vinj_pulse   <= (state_nxt == S_PULSE);
      done         <= (state_nxt == S_DONE);
      aborted      <= (state_nxt == S_DONE) && abort_flag_nxt;
    end
  end

endmodule

// File: tb/tb_fg_prog_sequencer.sv
// Self-checking bench for fg_prog_sequencer: directed scenarios plus randomized commands.
// Expected waveforms come from a timeline model (pulse windows computed arithmetically).
// Inputs are driven and outputs sampled on the falling edge.
module tb_fg_prog_sequencer;

  localparam int SETTLE = 4;
  localparam int GAP    = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_row;
  logic [3:0]  cmd_col;
  logic [7:0]  cmd_npulse;
  logic [15:0] cmd_width;
  logic        abort;
  logic [2:0]  row_addr;
  logic [3:0]  col_addr;
  logic        dec_en;
  logic        drain_sel_en;
  logic        vinj_pulse;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  pulse_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  fg_prog_sequencer #(.SETTLE_CYC(SETTLE), .GAP_CYC(GAP)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_row      (cmd_row),
    .cmd_col      (cmd_col),
    .cmd_npulse   (cmd_npulse),
    .cmd_width    (cmd_width),
    .abort        (abort),
    .row_addr     (row_addr),
    .col_addr     (col_addr),
    .dec_en       (dec_en),
    .drain_sel_en (drain_sel_en),
    .vinj_pulse   (vinj_pulse),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .pulse_cnt    (pulse_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int t, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s t=%0d: got %0d expected %0d", tag, t, got, exp);
  endtask

  task automatic check_reset_vals(input int t);
    check_eq("rst_row",   t, int'(row_addr),     0);
    check_eq("rst_col",   t, int'(col_addr),     0);
    check_eq("rst_cnt",   t, int'(pulse_cnt),    0);
    check_eq("rst_dec",   t, int'(dec_en),       0);
    check_eq("rst_drain", t, int'(drain_sel_en), 0);
    check_eq("rst_vinj",  t, int'(vinj_pulse),   0);
    check_eq("rst_busy",  t, int'(busy),         0);
    check_eq("rst_done",  t, int'(done),         0);
    check_eq("rst_abt",   t, int'(aborted),      0);
    check_eq("rst_ready", t, int'(cmd_ready),    1);
  endtask

  // Runs one command from acceptance (cycle 0) to the first IDLE cycle after done.
  // abort_at: cycle in which abort is held (0 = never); reset_at: cycle in which reset is held.
  task automatic run_cmd(input logic [2:0] r, input logic [3:0] c, input logic [7:0] np,
                         input logic [15:0] w, input int abort_at, input int reset_at,
                         input bit hold_valid, input bit abort_with_cmd);
    int wv, dnat, dn, cut, cnt, st, en, n, guard;
    bit ab, inp;
    guard = 0;
    while (!cmd_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check_eq("ready_timeout", guard, 0, 1);
      return;
    end
    cmd_row    = r;
    cmd_col    = c;
    cmd_npulse = np;
    cmd_width  = w;
    cmd_valid  = 1'b1;
    abort      = abort_with_cmd;

    n    = int'(np);
    wv   = (w == 16'd0) ? 1 : int'(w);
    dnat = (n == 0) ? SETTLE + 1 : SETTLE + 1 + n * wv + (n - 1) * GAP;
    ab   = (abort_at >= 1) && (abort_at < dnat);
    dn   = ab ? abort_at + 1 : dnat;
    cut  = ab ? abort_at + 1 : 1 << 30;

    for (int t = 1; t <= dn + 1; t++) begin
      @(negedge clk);
      if (reset_at != 0 && t == reset_at + 1) begin
        check_reset_vals(t);
        reset     = 1'b0;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        return;
      end
      inp = 1'b0;
      cnt = 0;
      for (int k = 0; k < n; k++) begin
        st = SETTLE + 1 + k * (wv + GAP);
        en = st + wv - 1;
        if (t >= st && t <= en && t < dn) inp = 1'b1;
        if (en < t && en < cut) cnt++;
      end
      check_eq("vinj",  t, int'(vinj_pulse),   int'(inp));
      check_eq("dec",   t, int'(dec_en),       int'(t < dn));
      check_eq("drain", t, int'(drain_sel_en), int'(t < dn));
      check_eq("busy",  t, int'(busy),         int'(t <= dn));
      check_eq("done",  t, int'(done),         int'(t == dn));
      check_eq("abt",   t, int'(aborted),      int'(t == dn && ab));
      check_eq("ready", t, int'(cmd_ready),    int'(t > dn));
      check_eq("cnt",   t, int'(pulse_cnt),    cnt);
      check_eq("row",   t, int'(row_addr),     int'(r));
      check_eq("col",   t, int'(col_addr),     int'(c));

      // Next-cycle drive: busy-time field noise, held cmd_valid, abort, reset.
      cmd_row    = 3'($urandom);
      cmd_col    = 4'($urandom);
      cmd_npulse = 8'($urandom);
      cmd_width  = 16'($urandom);
      cmd_valid  = hold_valid && (t <= dn);
      abort      = (t == abort_at) || (t == dn && $urandom_range(0, 1) == 1);
      reset      = (t == reset_at);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    int np, w, ab_at, wv, dnat;
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    abort      = 1'b0;
    cmd_row    = 3'd0;
    cmd_col    = 4'd0;
    cmd_npulse = 8'd0;
    cmd_width  = 16'd0;
    repeat (2) @(negedge clk);
    check_reset_vals(0);
    reset = 1'b0;

    // Basic three-pulse sequence
    run_cmd(3'd5, 4'd9, 8'd3, 16'd10, 0, 0, 1'b0, 1'b0);
    // No pulses
    run_cmd(3'd2, 4'd4, 8'd0, 16'd10, 0, 0, 1'b0, 1'b0);
    // Zero width treated as one cycle
    run_cmd(3'd7, 4'd15, 8'd2, 16'd0, 0, 0, 1'b0, 1'b0);
    // Abort during the second pulse
    run_cmd(3'd5, 4'd9, 8'd3, 16'd10, 25, 0, 1'b0, 1'b0);
    // Reset in the middle of the first pulse, then a command right away
    run_cmd(3'd5, 4'd9, 8'd3, 16'd10, 0, 8, 1'b0, 1'b0);
    run_cmd(3'd1, 4'd3, 8'd1, 16'd2, 0, 0, 1'b0, 1'b0);
    // cmd_valid held high throughout, abort offered together with the command
    run_cmd(3'd6, 4'd10, 8'd2, 16'd3, 0, 0, 1'b1, 1'b1);
    run_cmd(3'd4, 4'd6, 8'd1, 16'd1, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      np   = $urandom_range(0, 5);
      w    = $urandom_range(0, 12);
      wv   = (w == 0) ? 1 : w;
      dnat = (np == 0) ? SETTLE + 1 : SETTLE + 1 + np * wv + (np - 1) * GAP;
      ab_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, dnat + 2) : 0;
      run_cmd(3'($urandom), 4'($urandom), 8'(np), 16'(w), ab_at, 0,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
